// File: rtl/clkgen_prog.sv
// clkgen_prog: runtime M/D reprogramming sequencer for a DCM_CLKGEN.
// A request arrives over a valid/ready handshake. The block then shifts the LoadD,
// LoadM and GO commands out on PROGEN/PROGDATA, waits for PROGDONE and for the
// synchronised LOCKED, and ends with a one-cycle done or err pulse.
// clk also serves as the DCM PROGCLK.
//
// Ports:
//   clk, rst             programming clock; asynchronous active-high reset
//   req_valid/req_ready  request handshake; req_ready is high only when idle
//   req_m, req_d         encoded M-1 / D-1 of the request
//   prog_en, prog_data   registered drive for DCM PROGEN / PROGDATA
//   progdone             DCM PROGDONE (synchronous to clk)
//   locked               DCM LOCKED (asynchronous, synchronised internally)
//   busy                 high whenever the sequencer is not idle
//   done, err            one-cycle completion pulses; err_code gives the failure cause
//   cur_m, cur_d         encoded M-1 / D-1 of the last successful programming
module clkgen_prog #(
  parameter int unsigned MD_W    = 8,
  parameter int unsigned TO_W    = 20,
  parameter int unsigned TIMEOUT = 500000,
  parameter int unsigned DEF_M   = 2,
  parameter int unsigned DEF_D   = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [MD_W-1:0] req_m,
  input  logic [MD_W-1:0] req_d,
  output logic            prog_en,
  output logic            prog_data,
  input  logic            progdone,
  input  logic            locked,
  output logic            busy,
  output logic            done,
  output logic            err,
  output logic [1:0]      err_code,
  output logic [MD_W-1:0] cur_m,
  output logic [MD_W-1:0] cur_d
);

  localparam int unsigned SR_W = MD_W + 2;  // two command bits plus the value
  localparam logic [3:0]      ShiftLast = 4'(SR_W - 1);
  localparam logic [TO_W-1:0] TmoLast   = TO_W'(TIMEOUT - 1);
  localparam logic [MD_W-1:0] DefMEnc   = MD_W'(DEF_M - 1);
  localparam logic [MD_W-1:0] DefDEnc   = MD_W'(DEF_D - 1);

  typedef enum logic [3:0] {
    StIdle, StLoadD, StGap1, StLoadM, StGap2, StGo, StWaitDone, StWaitLock, StEnd
  } state_e;

  state_e          state_q, state_d;
  logic [3:0]      cnt_q, cnt_d;
  logic [SR_W-1:0] sr_q, sr_d;
  logic [TO_W-1:0] tmo_q, tmo_d;
  logic [MD_W-1:0] m_q, m_d, d_q, d_d;
  logic [MD_W-1:0] cur_m_q, cur_m_d, cur_d_q, cur_d_d;
  logic            prog_en_q, prog_en_d, prog_data_q, prog_data_d;
  logic            done_q, done_d, err_q, err_d;
  logic [1:0]      err_code_q, err_code_d;
  logic            locked_meta_q, locked_s_q;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    sr_d        = sr_q;
    tmo_d       = tmo_q;
    m_d         = m_q;
    d_d         = d_q;
    cur_m_d     = cur_m_q;
    cur_d_d     = cur_d_q;
    prog_en_d   = 1'b0;
    prog_data_d = 1'b0;
    done_d      = 1'b0;
    err_d       = 1'b0;
    err_code_d  = err_code_q;

    unique case (state_q)
      StIdle: begin
        if (req_valid) begin
          m_d        = req_m;
          d_d        = req_d;
          err_code_d = 2'd0;
          // M=1 is rejected here, so no PROGEN activity ever starts.
          if (req_m == '0) begin
            err_d      = 1'b1;
            err_code_d = 2'd1;
            state_d    = StEnd;
          end else begin
            sr_d        = {req_d, 2'b01};
            cnt_d       = 4'd0;
            prog_en_d   = 1'b1;
            prog_data_d = sr_d[0];
            state_d     = StLoadD;
          end
        end
      end
      StLoadD, StLoadM: begin
        if (cnt_q == ShiftLast) begin
          state_d = (state_q == StLoadD) ? StGap1 : StGap2;
        end else begin
          cnt_d       = cnt_q + 4'd1;
          // Rotate rather than shift; the wrapped bit never reaches the pin.
          sr_d        = {sr_q[0], sr_q[SR_W-1:1]};
          prog_en_d   = 1'b1;
          prog_data_d = sr_d[0];
        end
      end
      StGap1: begin
        sr_d        = {m_q, 2'b11};
        cnt_d       = 4'd0;
        prog_en_d   = 1'b1;
        prog_data_d = sr_d[0];
        state_d     = StLoadM;
      end
      StGap2: begin
        prog_en_d = 1'b1;  // GO command: PROGEN high with PROGDATA low
        state_d   = StGo;
      end
      StGo: begin
        tmo_d   = '0;
        state_d = StWaitDone;
      end
      StWaitDone: begin
        // The exit condition is tested first, so it wins over a same-cycle timeout.
        if (progdone) begin
          tmo_d   = '0;
          state_d = StWaitLock;
        end else if (tmo_q == TmoLast) begin
          err_d      = 1'b1;
          err_code_d = 2'd2;
          state_d    = StEnd;
        end else begin
          tmo_d = tmo_q + TO_W'(1);
        end
      end
      StWaitLock: begin
        if (locked_s_q) begin
          cur_m_d = m_q;
          cur_d_d = d_q;
          done_d  = 1'b1;
          state_d = StEnd;
        end else if (tmo_q == TmoLast) begin
          err_d      = 1'b1;
          err_code_d = 2'd3;
          state_d    = StEnd;
        end else begin
          tmo_d = tmo_q + TO_W'(1);
        end
      end
      StEnd: begin
        // This is the done/err pulse cycle; it stays busy until the pulse ends.
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= StIdle;
      cnt_q         <= '0;
      sr_q          <= '0;
      tmo_q         <= '0;
      m_q           <= '0;
      d_q           <= '0;
      cur_m_q       <= DefMEnc;
      cur_d_q       <= DefDEnc;
      prog_en_q     <= 1'b0;
      prog_data_q   <= 1'b0;
      done_q        <= 1'b0;
      err_q         <= 1'b0;
      err_code_q    <= 2'd0;
      locked_meta_q <= 1'b0;
      locked_s_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      sr_q          <= sr_d;
      tmo_q         <= tmo_d;
      m_q           <= m_d;
      d_q           <= d_d;
      cur_m_q       <= cur_m_d;
      cur_d_q       <= cur_d_d;
      prog_en_q     <= prog_en_d;
      prog_data_q   <= prog_data_d;
      done_q        <= done_d;
      err_q         <= err_d;
      err_code_q    <= err_code_d;
      locked_meta_q <= locked;
      locked_s_q    <= locked_meta_q;
    end
  end

  assign req_ready = (state_q == StIdle) && !rst;
  assign busy      = (state_q != StIdle);
  assign prog_en   = prog_en_q;
  assign prog_data = prog_data_q;
  assign done      = done_q;
  assign err       = err_q;
  assign err_code  = err_code_q;
  assign cur_m     = cur_m_q;
  assign cur_d     = cur_d_q;

endmodule

// File: tb/tb_clkgen_prog.sv
// Bench for clkgen_prog. A cycle-index model predicts every output from the
// request, the scheduled progdone/locked stimulus and the timeout rules.
module tb_clkgen_prog;
  localparam int unsigned Tmo = 64;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       req_valid = 1'b0;
  logic       req_ready;
  logic [7:0] req_m = '0, req_d = '0;
  logic       prog_en, prog_data;
  logic       progdone = 1'b0, locked = 1'b0;
  logic       busy, done, err;
  logic [1:0] err_code;
  logic [7:0] cur_m, cur_d;

  clkgen_prog #(.MD_W(8), .TO_W(20), .TIMEOUT(Tmo), .DEF_M(2), .DEF_D(1)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_m     (req_m),
    .req_d     (req_d),
    .prog_en   (prog_en),
    .prog_data (prog_data),
    .progdone  (progdone),
    .locked    (locked),
    .busy      (busy),
    .done      (done),
    .err       (err),
    .err_code  (err_code),
    .cur_m     (cur_m),
    .cur_d     (cur_d)
  );

  always #5 clk = ~clk;

  // Model state: n is the cycle index since the accepting edge (cycle 1 follows it).
  bit         m_active = 1'b0;
  int         n = 0;
  int         end_cyc = 0;
  bit         succ = 1'b0;
  logic [1:0] code_fin = '0;
  logic [7:0] lm = '0, ld = '0;
  logic [7:0] cur_m_e = 8'd1, cur_d_e = 8'd0;
  logic [1:0] err_code_e = '0;
  int         pd_cyc = -1, lk_cyc = -1;  // stimulus schedule, -1 = never
  logic [23:0] cap_pe = '0, cap_pd = '0;
  int         done_at = -1, err_at = -1;
  int         n_chk = 0, n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Outcome of a transaction from the schedule: the cycle of its done/err pulse.
  task automatic plan_txn();
    int wl, det;
    if (lm == 8'd0) begin
      end_cyc = 1; succ = 1'b0; code_fin = 2'd1;
    end else if (pd_cyc < 24 || pd_cyc > 24 + int'(Tmo) - 1) begin
      end_cyc = 24 + int'(Tmo); succ = 1'b0; code_fin = 2'd2;
    end else begin
      wl  = pd_cyc + 1;
      // Raw locked seen through two flops: visible two cycles after it rises.
      det = (lk_cyc < 0) ? -1 : ((lk_cyc + 2 > wl) ? lk_cyc + 2 : wl);
      if (det < 0 || det > wl + int'(Tmo) - 1) begin
        end_cyc = wl + int'(Tmo); succ = 1'b0; code_fin = 2'd3;
      end else begin
        end_cyc = det + 1; succ = 1'b1; code_fin = 2'd0;
      end
    end
  endtask

  task automatic finish_txn();
    if (succ) begin
      cur_m_e = lm; cur_d_e = ld;
    end else begin
      err_code_e = code_fin;
    end
  endtask

  initial forever begin
    @(posedge clk or posedge rst);
    if (rst) begin
      m_active = 1'b0; n = 0; cur_m_e = 8'd1; cur_d_e = 8'd0; err_code_e = 2'd0;
    end else if (m_active) begin
      if (n == end_cyc) begin
        m_active = 1'b0; n = 0;
      end else begin
        n++;
        if (n == end_cyc) finish_txn();
      end
    end else if (req_valid) begin
      m_active = 1'b1; n = 1; lm = req_m; ld = req_d; err_code_e = 2'd0;
      cap_pe = '0; cap_pd = '0; done_at = -1; err_at = -1;
      plan_txn();
      if (n == end_cyc) finish_txn();
    end
  end

  // DCM side: progdone is a one-cycle pulse, raw locked stays high once raised.
  initial forever begin
    @(posedge clk);
    #1;
    progdone = m_active && (n == pd_cyc);
    locked   = m_active && (lk_cyc >= 0) && (n >= lk_cyc);
  end

  function automatic logic exp_pe();
    return m_active && (lm != 8'd0) && ((n >= 1 && n <= 10) || (n >= 12 && n <= 21) || n == 23);
  endfunction

  function automatic logic exp_pd();
    int k;
    if (!m_active || lm == 8'd0) return 1'b0;
    if (n >= 1 && n <= 10) begin
      k = n - 1;
      return (k < 2) ? (k == 0) : ld[k-2];
    end
    if (n >= 12 && n <= 21) begin
      k = n - 12;
      return (k < 2) ? 1'b1 : lm[k-2];
    end
    return 1'b0;
  endfunction

  initial forever begin
    @(negedge clk);
    chk("prog_en",   prog_en,   exp_pe());
    chk("prog_data", prog_data, exp_pd());
    chk("busy",      busy,      m_active);
    chk("req_ready", req_ready, !m_active && !rst);
    chk("done",      done,      m_active && n == end_cyc && succ);
    chk("err",       err,       m_active && n == end_cyc && !succ);
    chk("err_code",  err_code,  err_code_e);
    chk("cur_m",     cur_m,     cur_m_e);
    chk("cur_d",     cur_d,     cur_d_e);
    if (m_active && n >= 1 && n <= 23) begin
      cap_pe[n] = prog_en;
      cap_pd[n] = prog_data;
    end
    if (m_active && done) done_at = n;
    if (m_active && err) err_at = n;
  end

  task automatic request(input logic [7:0] m, input logic [7:0] d, input int pd, input int lk);
    @(negedge clk);
    pd_cyc = pd; lk_cyc = lk;
    req_m = m; req_d = d; req_valid = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0;
  endtask

  task automatic wait_txn();
    int b = 0;
    while (m_active && b < 400) begin
      @(posedge clk);
      b++;
    end
    if (m_active) begin
      n_chk++; n_fail++;
      $display("FAIL wait_txn: still busy after %0d cycles, required idle", b);
    end
    @(negedge clk);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #3 rst = 1'b0;
    repeat (100) @(posedge clk);
    @(negedge clk);
    chk("rst_cur_m", cur_m, 32'd1);
    chk("rst_cur_d", cur_d, 32'd0);
    chk("rst_ready", req_ready, 32'd1);

    // M=4, D=2; a request presented while busy must be ignored.
    request(8'd3, 8'd1, 30, 38);
    repeat (3) @(negedge clk);
    req_m = 8'hAA; req_d = 8'h55; req_valid = 1'b1;
    repeat (3) @(negedge clk);
    req_valid = 1'b0;
    wait_txn();
    chk("seq_data", cap_pd, 32'h00F00A);
    chk("seq_en", cap_pe, 32'hBFF7FE);
    chk("done_cycle", done_at, 32'd41);
    chk("no_err", err_at, -32'sd1);
    chk("ok_cur_m", cur_m, 32'd3);
    chk("ok_cur_d", cur_d, 32'd1);

    // Illegal M=1.
    request(8'd0, 8'd5, -1, -1);
    wait_txn();
    chk("illegal_err_cycle", err_at, 32'd1);
    chk("illegal_no_prog", cap_pe, 32'd0);
    chk("illegal_code", err_code, 32'd1);
    chk("illegal_cur_m", cur_m, 32'd3);

    // PROGDONE never arrives.
    request(8'd9, 8'd4, -1, -1);
    wait_txn();
    chk("pd_tmo_cycle", err_at, 32'd88);
    chk("pd_tmo_code", err_code, 32'd2);
    chk("pd_tmo_ready", req_ready, 32'd1);
    chk("pd_tmo_cur_d", cur_d, 32'd1);

    // LOCKED never arrives, then a normal request clears err_code.
    request(8'd4, 8'd2, 30, -1);
    wait_txn();
    chk("lk_tmo_cycle", err_at, 32'd95);
    chk("lk_tmo_code", err_code, 32'd3);
    request(8'h5A, 8'hC3, 24, 10);
    wait_txn();
    chk("fast_done_cycle", done_at, 32'd26);
    chk("fast_code", err_code, 32'd0);
    chk("fast_cur_m", cur_m, 32'h5A);

    // Both exit conditions land on the last allowed cycle of their waits.
    request(8'h10, 8'h20, 87, 149);
    wait_txn();
    chk("edge_done_cycle", done_at, 32'd152);
    chk("edge_cur_d", cur_d, 32'h20);

    // Reset in the middle of LOAD_M.
    request(8'd7, 8'h80, 40, 50);
    repeat (14) @(posedge clk);
    #3 rst = 1'b1;
    #1;
    chk("rst_async_pe", prog_en, 32'd0);
    chk("rst_async_cur_m", cur_m, 32'd1);
    chk("rst_async_busy", busy, 32'd0);
    repeat (2) @(posedge clk);
    #3 rst = 1'b0;
    request(8'hFF, 8'hFF, 40, 50);
    wait_txn();
    chk("post_rst_done_cycle", done_at, 32'd53);
    chk("post_rst_cur_m", cur_m, 32'hFF);
    chk("post_rst_seq_en", cap_pe, 32'hBFF7FE);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/clkgen_prog.md
Name: clkgen_prog

Overview:
- Runtime reprogramming sequencer for the DCM_CLKGEN frequency synthesiser. Accepts a new M/D request over a valid/ready handshake and shifts LoadD, LoadM and GO commands onto the PROGEN/PROGDATA pins.
- Then waits for PROGDONE and re-LOCK, and reports done or error. Sits beside the clock generator; its clk drives DCM PROGCLK.
- Successor to the fixed-ratio generator: the multiply/divide ratio changes at run time instead of being frozen at build.

Parameters:
- MD_W, 8, width of M and D request fields. Must be 8 for DCM_CLKGEN.
- TO_W, 20, width of timeout counter.
- TIMEOUT, 500000, clk cycles allowed in each of WAIT_DONE and WAIT_LOCK before error.
- DEF_M, 2, reset value of cur_m.
- DEF_D, 1, reset value of cur_d.

Ports:
- clk  in  1  programming clock; also drives DCM PROGCLK.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  1  request strobe.
- req_ready  out  1  high when idle and able to accept a request.
- req_m  in  MD_W  multiply value M, legal range 2..256 (encoded M-1).
- req_d  in  MD_W  divide value D, legal range 1..256 (encoded D-1).
- prog_en  out  1  to DCM PROGEN.
- prog_data  out  1  to DCM PROGDATA.
- progdone  in  1  from DCM PROGDONE, synchronous to clk.
- locked  in  1  from DCM LOCKED, asynchronous; passes through a 2-FF synchroniser (locked_s).
- busy  out  1  high in any state except IDLE.
- done  out  1  one-cycle pulse on successful completion.
- err  out  1  one-cycle pulse on failure.
- err_code  out  2  cause of last failure: 0 none, 1 illegal M, 2 PROGDONE timeout, 3 LOCK timeout. Held until the next accepted request.
- cur_m, cur_d  out  MD_W  encoded M-1/D-1 of last successful programming.

Behaviour:
- Reset values: prog_en=0, prog_data=0, busy=0, done=0, err=0, err_code=0, cur_m=DEF_M-1, cur_d=DEF_D-1, state IDLE, timeout counter 0.
- req_ready = (state==IDLE) and not rst. Accept when req_valid && req_ready at edge T0.
- On accept, req_m/req_d are latched and err_code is cleared.
- Illegal M: latched encoded M == 0 (M=1). Next cycle: err=1, err_code=1, return to IDLE. No PROGEN activity. Every D value is legal.
- States and cycle offsets after T0:
  - LOAD_D, cycles 1..10: prog_en=1. prog_data sequence is 1, 0, then D-1 LSB-first (8 bits).
  - GAP1, cycle 11: prog_en=0, prog_data=0.
  - LOAD_M, cycles 12..21: prog_en=1. prog_data sequence is 1, 1, then M-1 LSB-first.
  - GAP2, cycle 22: prog_en=0, prog_data=0.
  - GO, cycle 23: prog_en=1, prog_data=0, for exactly one cycle.
  - WAIT_DONE, from cycle 24: prog_en=0. On progdone==1, go to WAIT_LOCK and clear the counter.
  - WAIT_LOCK: on locked_s==1, update cur_m/cur_d from the latched values, pulse done=1 for one cycle, return to IDLE.
- prog_en and prog_data are registered outputs, so the values above appear on the pins in the stated cycle.
- Shift count uses a 4-bit counter; shift data comes from a 10-bit shift register loaded at state entry.
- Timeout counter counts cycles spent in each wait state. When it reaches TIMEOUT-1 with the exit condition still false: err=1, err_code=2 (in WAIT_DONE) or 3 (in WAIT_LOCK), go to IDLE. cur_m/cur_d stay unchanged.
- progdone already high on the first WAIT_DONE cycle is accepted immediately.
- Exit condition and timeout true in the same cycle: success wins.
- locked_s dropping during LOAD/GO is ignored; only WAIT_LOCK samples it.
- req_valid outside IDLE is ignored, with no queueing. Requester must hold req_valid until ready.
- rst asserted mid-sequence: all outputs return to reset values asynchronously. prog_en drops immediately. A partially shifted command is abandoned (DCM discards a command without GO).
- done and err are never high in the same cycle. busy=1 from T0+1 until the cycle of the done/err pulse inclusive.

Test Plan:
- Reset, then idle: cur_m=1, cur_d=0, req_ready=1, prog_en=0 held for 100 cycles.
- Request M=4, D=2; progdone at cycle 30; locked_s high at 40 -> prog_data on cycles 1..10 = 1,0,1,0,0,0,0,0,0,0; prog_en=0 at cycle 11; cycles 12..21 = 1,1,1,1,0,0,0,0,0,0; GO pulse at cycle 23; done pulse; cur_m=3, cur_d=1.
- Request with encoded req_m=0 -> err pulse with err_code=1 at T0+1; prog_en never asserted; cur_m/cur_d unchanged.
- progdone never asserted, TIMEOUT=64 -> err_code=2 exactly 64 cycles after entering WAIT_DONE; req_ready=1 the following cycle.
- locked held low after progdone -> err_code=3 after TIMEOUT cycles; next legal request clears err_code and completes normally.
- rst asserted at cycle 15 (mid LOAD_M) -> prog_en=0 without waiting for a clock edge; cur values back to defaults; a fresh request afterwards completes with the correct bit sequence.
